// File: rtl/mxu_input_skewer.sv
// mxu_input_skewer: re-times one activation vector per cycle into the diagonal wavefront
// mxu_core expects (lane i delayed i cycles), and tracks tile boundaries with a drain phase.
module mxu_input_skewer #(
    parameter int M              = 3,
    parameter int max_data_width = 4,
    parameter int CNT_W          = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        s_valid,
    output logic                        s_ready,
    input  logic [M*max_data_width-1:0] s_data,
    input  logic                        s_last,
    output logic [M*max_data_width-1:0] mxu_data,
    output logic [M-1:0]                lane_valid,
    output logic                        mxu_enable,
    output logic                        tile_done,
    output logic [CNT_W-1:0]            vec_count
);
    localparam int W  = max_data_width;
    localparam int DW = M > 2 ? $clog2(M - 1) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t        state;
    logic [DW-1:0] drain_cnt;
    logic          accept;
    logic          end_tile;

    assign accept   = s_valid & s_ready;
    assign end_tile = accept & s_last;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            drain_cnt <= '0;
            s_ready   <= 1'b0;
            tile_done <= 1'b0;
            vec_count <= '0;
        end else begin
            tile_done <= 1'b0;
            case (state)
                IDLE, RUN: begin
                    s_ready <= !end_tile;
                    if (end_tile) begin
                        state     <= M > 1 ? DRAIN : DONE;
                        drain_cnt <= DW'(M > 2 ? M - 2 : 0);
                        tile_done <= M == 1;
                    end else if (accept) begin
                        state <= RUN;
                    end
                end
                DRAIN: begin
                    if (drain_cnt == '0) begin
                        state     <= DONE;
                        tile_done <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt - 1'b1;
                    end
                end
                DONE: begin
                    state   <= IDLE;
                    s_ready <= 1'b1;
                end
                default: state <= IDLE;
            endcase
            // first accept of a tile restarts the count; later accepts saturate
            if (accept)
                vec_count <= state == IDLE ? CNT_W'(1) : (&vec_count ? vec_count : vec_count + 1'b1);
        end
    end

    for (genvar i = 0; i < M; i++) begin : g_lane
        logic [W-1:0] d [0:i];
        logic [i:0]   v;
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                for (int k = 0; k <= i; k++) d[k] <= '0;
                v <= '0;
            end else begin
                d[0] <= accept ? s_data[i*W +: W] : '0;
                for (int k = 1; k <= i; k++) d[k] <= d[k-1];
                v <= (i+1)'({v, accept});
            end
        end
        assign mxu_data[i*W +: W] = d[i];
        assign lane_valid[i]      = v[i];
    end

    assign mxu_enable = |lane_valid;
endmodule

// File: tb/tb_mxu_input_skewer.sv
// tb_mxu_input_skewer: vector table, corner sequences and random traffic against a
// cycle-history reference model; a second M=1 instance covers the single-lane case.
module tb_mxu_input_skewer;
    localparam int M = 3;
    localparam int W = 4;
    localparam int N = M * W;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic           s_valid = 1'b0;
    logic           s_last = 1'b0;
    logic [N-1:0]   s_data = '0;
    logic           s_ready;
    logic [N-1:0]   mxu_data;
    logic [M-1:0]   lane_valid;
    logic           mxu_enable;
    logic           tile_done;
    logic [15:0]    vec_count;

    logic           v1 = 1'b0;
    logic           l1 = 1'b0;
    logic [3:0]     d1 = '0;
    logic           r1_ready;
    logic [3:0]     r1_data;
    logic [0:0]     r1_lv;
    logic           r1_en;
    logic           r1_done;
    logic [15:0]    r1_cnt;

    mxu_input_skewer #(.M(M), .max_data_width(W), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .s_last(s_last), .mxu_data(mxu_data), .lane_valid(lane_valid), .mxu_enable(mxu_enable),
        .tile_done(tile_done), .vec_count(vec_count)
    );

    mxu_input_skewer #(.M(1), .max_data_width(4), .CNT_W(16)) dut1 (
        .clk(clk), .reset(reset), .s_valid(v1), .s_ready(r1_ready), .s_data(d1),
        .s_last(l1), .mxu_data(r1_data), .lane_valid(r1_lv), .mxu_enable(r1_en),
        .tile_done(r1_done), .vec_count(r1_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // reference model: history of what entered lane 0 each cycle, plus tile bookkeeping
    logic [N-1:0] hq[$];
    logic         vq[$];
    int           busy = 0;
    logic         m_ready = 1'b0;
    logic         open = 1'b0;
    logic [15:0]  vcnt = '0;

    typedef struct {
        logic         v;
        logic         l;
        logic [N-1:0] d;
        logic [N-1:0] ed;
        logic [M-1:0] elv;
        logic         edone;
        logic         erdy;
        logic [15:0]  ecnt;
    } vec_t;
    vec_t tbl[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        logic [N-1:0] ed;
        logic [M-1:0] ev;
        logic [N-1:0] tmp;
        ed = '0;
        ev = '0;
        for (int i = 0; i < M; i++) begin
            int idx;
            idx = hq.size() - 1 - i;
            if (idx >= 0) begin
                tmp = hq[idx];
                ed[i*W +: W] = tmp[i*W +: W];
                ev[i] = vq[idx];
            end
        end
        chk("mxu_data", mxu_data, ed);
        chk("lane_valid", lane_valid, ev);
        chk("mxu_enable", mxu_enable, |ev);
        chk("tile_done", tile_done, busy == 1);
        chk("s_ready", s_ready, m_ready);
        chk("vec_count", vec_count, vcnt);
    endtask

    task automatic tick();
        logic acc;
        logic end_t;
        acc   = s_valid && m_ready;
        end_t = acc && s_last;
        hq.push_back(acc ? s_data : '0);
        vq.push_back(acc);
        if (hq.size() > M) begin
            void'(hq.pop_front());
            void'(vq.pop_front());
        end
        if (acc) begin
            vcnt = open ? ((&vcnt) ? vcnt : vcnt + 16'd1) : 16'd1;
            open = !s_last;
        end
        @(posedge clk);
        #1;
        busy    = end_t ? M : (busy > 0 ? busy - 1 : 0);
        m_ready = (busy == 0);
        check_model();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #1;
        hq.delete();
        vq.delete();
        busy    = 0;
        m_ready = 1'b0;
        open    = 1'b0;
        vcnt    = '0;
        check_model();
        chk("m1_rst_ready", r1_ready, 0);
        chk("m1_rst_data", r1_data, 0);
        chk("m1_rst_lv", r1_lv, 0);
        chk("m1_rst_done", r1_done, 0);
        chk("m1_rst_cnt", r1_cnt, 0);
        repeat (2) begin
            @(posedge clk);
            #1;
            check_model();
        end
        reset = 1'b1;
    endtask

    initial begin
        tbl[0]  = '{1'b1, 1'b1, 12'h253, 12'h003, 3'b001, 1'b0, 1'b0, 16'd1};
        tbl[1]  = '{1'b0, 1'b0, 12'hFFF, 12'h050, 3'b010, 1'b0, 1'b0, 16'd1};
        tbl[2]  = '{1'b0, 1'b1, 12'hFFF, 12'h200, 3'b100, 1'b1, 1'b0, 16'd1};
        tbl[3]  = '{1'b0, 1'b0, 12'h000, 12'h000, 3'b000, 1'b0, 1'b1, 16'd1};
        tbl[4]  = '{1'b1, 1'b0, 12'h353, 12'h003, 3'b001, 1'b0, 1'b1, 16'd1};
        tbl[5]  = '{1'b1, 1'b0, 12'h463, 12'h053, 3'b011, 1'b0, 1'b1, 16'd2};
        tbl[6]  = '{1'b1, 1'b1, 12'h564, 12'h364, 3'b111, 1'b0, 1'b0, 16'd3};
        tbl[7]  = '{1'b1, 1'b0, 12'hABC, 12'h460, 3'b110, 1'b0, 1'b0, 16'd3};
        tbl[8]  = '{1'b1, 1'b1, 12'hABC, 12'h500, 3'b100, 1'b1, 1'b0, 16'd3};
        tbl[9]  = '{1'b1, 1'b0, 12'hABC, 12'h000, 3'b000, 1'b0, 1'b1, 16'd3};
        tbl[10] = '{1'b1, 1'b0, 12'h353, 12'h003, 3'b001, 1'b0, 1'b1, 16'd1};
        tbl[11] = '{1'b0, 1'b0, 12'hFFF, 12'h050, 3'b010, 1'b0, 1'b1, 16'd1};
        tbl[12] = '{1'b1, 1'b1, 12'h564, 12'h304, 3'b101, 1'b0, 1'b0, 16'd2};
        tbl[13] = '{1'b0, 1'b0, 12'hFFF, 12'h060, 3'b010, 1'b0, 1'b0, 16'd2};
        tbl[14] = '{1'b0, 1'b0, 12'hFFF, 12'h500, 3'b100, 1'b1, 1'b0, 16'd2};
        tbl[15] = '{1'b0, 1'b0, 12'hFFF, 12'h000, 3'b000, 1'b0, 1'b1, 16'd2};

        // reset held with a pending vector: nothing is accepted
        s_valid = 1'b1;
        s_data  = 12'h999;
        do_reset();
        tick();
        s_valid = 1'b0;

        for (int r = 0; r < 16; r++) begin
            s_valid = tbl[r].v;
            s_last  = tbl[r].l;
            s_data  = tbl[r].d;
            tick();
            chk($sformatf("tbl%0d_data", r), mxu_data, tbl[r].ed);
            chk($sformatf("tbl%0d_lv", r), lane_valid, tbl[r].elv);
            chk($sformatf("tbl%0d_en", r), mxu_enable, |tbl[r].elv);
            chk($sformatf("tbl%0d_done", r), tile_done, tbl[r].edone);
            chk($sformatf("tbl%0d_ready", r), s_ready, tbl[r].erdy);
            chk($sformatf("tbl%0d_cnt", r), vec_count, tbl[r].ecnt);
        end

        // reset during the drain of a three-vector tile
        s_valid = 1'b1; s_last = 1'b0; s_data = 12'h353; tick();
        s_data = 12'h463; tick();
        s_last = 1'b1; s_data = 12'h564; tick();
        s_valid = 1'b0; s_last = 1'b0;
        do_reset();
        repeat (4) tick();
        chk("post_rst_ready", s_ready, 1);
        s_valid = 1'b1; s_data = 12'h777; tick();
        chk("post_rst_cnt", vec_count, 1);
        s_last = 1'b1; s_data = 12'h888; tick();
        s_valid = 1'b0; s_last = 1'b0;
        repeat (5) tick();

        // randomized traffic, including s_last without s_valid
        for (int c = 0; c < 400; c++) begin
            s_valid = $urandom_range(0, 9) < 7;
            s_last  = $urandom_range(0, 9) < 2;
            s_data  = N'($urandom);
            tick();
        end
        s_valid = 1'b0; s_last = 1'b0;
        repeat (6) tick();

        // single-lane instance: back-to-back tiles
        v1 = 1'b1; l1 = 1'b1; d1 = 4'h9;
        tick();
        chk("m1_t1_data", r1_data, 4'h9);
        chk("m1_t1_lv", r1_lv, 1);
        chk("m1_t1_en", r1_en, 1);
        chk("m1_t1_done", r1_done, 1);
        chk("m1_t1_ready", r1_ready, 0);
        chk("m1_t1_cnt", r1_cnt, 1);
        d1 = 4'hA;
        tick();
        chk("m1_t2_data", r1_data, 0);
        chk("m1_t2_lv", r1_lv, 0);
        chk("m1_t2_done", r1_done, 0);
        chk("m1_t2_ready", r1_ready, 1);
        tick();
        chk("m1_t3_data", r1_data, 4'hA);
        chk("m1_t3_done", r1_done, 1);
        chk("m1_t3_ready", r1_ready, 0);
        chk("m1_t3_cnt", r1_cnt, 1);
        v1 = 1'b0; l1 = 1'b0;
        tick();
        chk("m1_t4_lv", r1_lv, 0);
        chk("m1_t4_done", r1_done, 0);
        chk("m1_t4_ready", r1_ready, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
